// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - issue/CDB/commit bundle between the core and the reorder buffer
interface reorder_buffer_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  logic                     alloc_valid;
  logic [4:0]               alloc_rd;
  logic                     alloc_ready;
  logic [ROB_WIDTH_BIT-1:0] alloc_rob_id;
  logic [4:0]               set_dep_reg_id;
  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id;
  logic                     wb_valid;
  logic [ROB_WIDTH_BIT-1:0] wb_rob_id;
  logic [31:0]              wb_val;
  logic [ROB_WIDTH_BIT-1:0] query_id1;
  logic [ROB_WIDTH_BIT-1:0] query_id2;
  logic                     query_ready1;
  logic                     query_ready2;
  logic [31:0]              query_val1;
  logic [31:0]              query_val2;
  logic [4:0]               set_reg_id;
  logic [31:0]              set_val;
  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id;

  // Issue/CDB/register-file side
  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_rob_id, wb_val, query_id1, query_id2,
    input  alloc_ready, alloc_rob_id, set_dep_reg_id, set_dep_rob_id,
           query_ready1, query_ready2, query_val1, query_val2,
           set_reg_id, set_val, set_reg_on_rob_id
  );

  // Reorder buffer side
  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_rob_id, wb_val, query_id1, query_id2,
    output alloc_ready, alloc_rob_id, set_dep_reg_id, set_dep_rob_id,
           query_ready1, query_ready2, query_val1, query_val2,
           set_reg_id, set_val, set_reg_on_rob_id
  );
endinterface

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer; optional ROB_COMMIT_BYPASS_EN
module reorder_buffer #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  reorder_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ROB_WIDTH_BIT;

  typedef logic [ROB_WIDTH_BIT-1:0] idx_t;
  typedef logic [ROB_WIDTH_BIT:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [4:0]       rd  [DEPTH];
  logic [31:0]      val [DEPTH];
  idx_t             head;
  idx_t             tail;
  cnt_t             count;

  logic             accept;
  logic             commit;
  logic             wb_hit;
  logic [31:0]      commit_val;
  logic             q1_hit;
  logic             q2_hit;

  // A CDB result only lands on an entry that is still in flight
  assign wb_hit = bus.wb_valid && busy[bus.wb_rob_id];

`ifdef ROB_COMMIT_BYPASS_EN
  logic head_wb_hit;
  assign head_wb_hit = wb_hit && (bus.wb_rob_id == head);
  // Head may retire on the very cycle its result shows up on the CDB
  assign commit     = rdy_in && !flush_in && busy[head] && (ready[head] || head_wb_hit);
  assign commit_val = ready[head] ? val[head] : bus.wb_val;
`else
  assign commit     = rdy_in && !flush_in && busy[head] && ready[head];
  assign commit_val = val[head];
`endif

  // Allocation handshake and rename port; full blocks even when a commit frees a slot
  always_comb begin
    bus.alloc_ready    = rdy_in && !flush_in && (count != FULL);
    accept             = bus.alloc_valid && bus.alloc_ready;
    bus.alloc_rob_id   = tail;
    bus.set_dep_rob_id = tail;
    bus.set_dep_reg_id = accept ? bus.alloc_rd : 5'd0;
  end

  // Commit port, zeroed whenever the head does not retire this cycle
  always_comb begin
    bus.set_reg_id        = 5'd0;
    bus.set_val           = 32'd0;
    bus.set_reg_on_rob_id = '0;
    if (commit) begin
      bus.set_reg_id        = rd[head];
      bus.set_val           = commit_val;
      bus.set_reg_on_rob_id = head;
    end
  end

  // Operand queries, with a same-cycle bypass from the CDB
  always_comb begin
    q1_hit           = bus.wb_valid && (bus.wb_rob_id == bus.query_id1) && busy[bus.query_id1];
    q2_hit           = bus.wb_valid && (bus.wb_rob_id == bus.query_id2) && busy[bus.query_id2];
    bus.query_ready1 = (busy[bus.query_id1] && ready[bus.query_id1]) || q1_hit;
    bus.query_ready2 = (busy[bus.query_id2] && ready[bus.query_id2]) || q2_hit;
    bus.query_val1   = q1_hit ? bus.wb_val : val[bus.query_id1];
    bus.query_val2   = q2_hit ? bus.wb_val : val[bus.query_id2];
  end

  // Entry state and pointers: writeback, then retire (also drops ready so a freed
  // entry never looks complete), then allocate; paused cycles change nothing
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy  <= '0;
      ready <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i]  <= '0;
        val[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (wb_hit) begin
          ready[bus.wb_rob_id] <= 1'b1;
          val[bus.wb_rob_id]   <= bus.wb_val;
        end
        if (commit) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + idx_t'(1);
        end
        if (accept) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          rd[tail]    <= bus.alloc_rd;
          tail        <= tail + idx_t'(1);
        end
        count <= count + cnt_t'(accept) - cnt_t'(commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer against a queue model
module tb_reorder_buffer;
  localparam int W = 4;
  localparam int D = 16;
`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic rdy;
  logic flush;

  reorder_buffer_if #(.ROB_WIDTH_BIT(W)) bus ();

  reorder_buffer #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .flush_in (flush),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t m_q[$];
  int   m_head = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of an id in age order, or -1 if that entry is not in flight
  function automatic int age_pos(input logic [W-1:0] id);
    int p;
    p = (int'(id) - m_head + D) % D;
    return (p < m_q.size()) ? p : -1;
  endfunction

  task automatic qcheck(input string name, input logic [W-1:0] id,
                        input logic r_act, input logic [31:0] v_act);
    int  p;
    bit  hit;
    bit  r;
    p   = age_pos(id);
    hit = bus.wb_valid && (bus.wb_rob_id == id) && (p >= 0);
    r   = (p >= 0) && (m_q[p].done || hit);
    chk({name, "_ready"}, {31'b0, r_act}, {31'b0, r});
    if (r) chk({name, "_val"}, v_act, hit ? bus.wb_val : m_q[p].val);
  endtask

  // Compare process: every cycle, outputs vs model, then advance the model
  always @(negedge clk) begin
    int          wpos;
    bit          e_ar;
    bit          e_acc;
    bit          e_com;
    logic [31:0] e_val;
    int          e_tail;
    if (!rst_n) begin
      chk("rst_alloc_ready", {31'b0, bus.alloc_ready}, {31'b0, rdy && !flush});
      chk("rst_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
      chk("rst_set_dep_reg_id", 32'(bus.set_dep_reg_id), 32'd0);
      chk("rst_set_reg_id", 32'(bus.set_reg_id), 32'd0);
      chk("rst_set_val", bus.set_val, 32'd0);
      chk("rst_query_ready1", {31'b0, bus.query_ready1}, 32'd0);
      m_q.delete();
      m_head = 0;
    end else begin
      e_ar   = rdy && !flush && (m_q.size() != D);
      e_acc  = bus.alloc_valid && e_ar;
      e_tail = (m_head + m_q.size()) % D;
      wpos   = bus.wb_valid ? age_pos(bus.wb_rob_id) : -1;
      e_com  = 1'b0;
      e_val  = 32'd0;
      if (rdy && !flush && m_q.size() > 0) begin
        e_com = m_q[0].done || (BYP && wpos == 0);
        e_val = m_q[0].done ? m_q[0].val : bus.wb_val;
      end
      chk("alloc_ready", {31'b0, bus.alloc_ready}, {31'b0, e_ar});
      chk("alloc_rob_id", 32'(bus.alloc_rob_id), 32'(e_tail));
      chk("set_dep_rob_id", 32'(bus.set_dep_rob_id), 32'(e_tail));
      chk("set_dep_reg_id", 32'(bus.set_dep_reg_id), e_acc ? 32'(bus.alloc_rd) : 32'd0);
      chk("set_reg_id", 32'(bus.set_reg_id), e_com ? 32'(m_q[0].rd) : 32'd0);
      chk("set_val", bus.set_val, e_com ? e_val : 32'd0);
      chk("set_reg_on_rob_id", 32'(bus.set_reg_on_rob_id), e_com ? 32'(m_head) : 32'd0);
      qcheck("query1", bus.query_id1, bus.query_ready1, bus.query_val1);
      qcheck("query2", bus.query_id2, bus.query_ready2, bus.query_val2);
      if (rdy) begin
        if (flush) begin
          m_q.delete();
          m_head = 0;
        end else begin
          if (wpos >= 0) begin
            m_q[wpos].done = 1'b1;
            m_q[wpos].val  = bus.wb_val;
          end
          if (e_com) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % D;
          end
          if (e_acc) m_q.push_back('{rd: bus.alloc_rd, done: 1'b0, val: 32'd0});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rdy             = 1'b1;
    flush           = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.alloc_rd    = 5'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_rob_id   = '0;
    bus.wb_val      = 32'd0;
    bus.query_id1   = '0;
    bus.query_id2   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [4:0] r);
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = r;
    cyc();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [W-1:0] id, input logic [31:0] v);
    bus.wb_valid  = 1'b1;
    bus.wb_rob_id = id;
    bus.wb_val    = v;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;

    // Reset state and first allocate/writeback/commit
    probe();
    chk("lit_reset_alloc_ready", {31'b0, bus.alloc_ready}, 32'd1);
    chk("lit_reset_set_reg_id", 32'(bus.set_reg_id), 32'd0);
    chk("lit_reset_query_val1", bus.query_val1, 32'd0);
    cyc();
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd5;
    probe();
    chk("lit_dep_reg_id", 32'(bus.set_dep_reg_id), 32'd5);
    chk("lit_dep_rob_id", 32'(bus.set_dep_rob_id), 32'd0);
    cyc();
    bus.alloc_valid = 1'b0;
    wb(0, 32'h1234);
    probe();
`ifdef ROB_COMMIT_BYPASS_EN
    chk("lit_bypass_commit_rd", 32'(bus.set_reg_id), 32'd5);
    chk("lit_bypass_commit_val", bus.set_val, 32'h1234);
    cyc();
    bus.wb_valid = 1'b0;
`else
    chk("lit_no_commit_same_cycle", 32'(bus.set_reg_id), 32'd0);
    cyc();
    bus.wb_valid = 1'b0;
    probe();
    chk("lit_commit_rd", 32'(bus.set_reg_id), 32'd5);
    chk("lit_commit_val", bus.set_val, 32'h1234);
    chk("lit_commit_rob", 32'(bus.set_reg_on_rob_id), 32'd0);
    cyc();
`endif

    // Fill to full, refuse the 17th, retire one, wrap tail to 0
    do_reset();
    for (int i = 0; i < D; i++) alloc(5'(i + 1));
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd17;
    probe();
    chk("lit_full_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    chk("lit_full_dep_reg", 32'(bus.set_dep_reg_id), 32'd0);
    cyc();
    bus.alloc_valid = 1'b0;
    wb(0, 32'h55);
    probe();
    chk("lit_full_wb_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    cyc();
    bus.wb_valid = 1'b0;
`ifndef ROB_COMMIT_BYPASS_EN
    probe();
    chk("lit_full_commit_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    chk("lit_full_commit_rd", 32'(bus.set_reg_id), 32'd1);
    cyc();
`endif
    bus.alloc_valid = 1'b1;
    bus.alloc_rd    = 5'd9;
    probe();
    chk("lit_wrap_alloc_ready", {31'b0, bus.alloc_ready}, 32'd1);
    chk("lit_wrap_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    cyc();
    bus.alloc_valid = 1'b0;

    // Out-of-order writebacks retire in order
    do_reset();
    alloc(5'd1);
    alloc(5'd2);
    alloc(5'd3);
    wb(2, 32'h22);
    cyc();
    wb(1, 32'h11);
    cyc();
    wb(0, 32'h33);
`ifdef ROB_COMMIT_BYPASS_EN
    probe();
    chk("lit_ooo_c0_rd", 32'(bus.set_reg_id), 32'd1);
    cyc();
    bus.wb_valid = 1'b0;
`else
    cyc();
    bus.wb_valid = 1'b0;
    probe();
    chk("lit_ooo_c0_rd", 32'(bus.set_reg_id), 32'd1);
    chk("lit_ooo_c0_val", bus.set_val, 32'h33);
    cyc();
`endif
    probe();
    chk("lit_ooo_c1_rob", 32'(bus.set_reg_on_rob_id), 32'd1);
    chk("lit_ooo_c1_val", bus.set_val, 32'h11);
    cyc();
    probe();
    chk("lit_ooo_c2_rob", 32'(bus.set_reg_on_rob_id), 32'd2);
    chk("lit_ooo_c2_rd", 32'(bus.set_reg_id), 32'd3);
    cyc();

    // Query bypass from the CDB
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1));
    wb(3, 32'hABCD);
    bus.query_id1 = 3;
    bus.query_id2 = 3;
    probe();
    chk("lit_query_bypass_ready", {31'b0, bus.query_ready1}, 32'd1);
    chk("lit_query_bypass_val", bus.query_val1, 32'hABCD);
    cyc();
    bus.wb_valid  = 1'b0;
    bus.query_id1 = 2;
    probe();
    chk("lit_query_not_ready", {31'b0, bus.query_ready1}, 32'd0);
    chk("lit_query_reg_val", bus.query_val2, 32'hABCD);
    cyc();

    // Flush with 8 in flight
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1));
    flush           = 1'b1;
    bus.alloc_valid = 1'b1;
    wb(3, 32'h7);
    probe();
    chk("lit_flush_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    chk("lit_flush_set_reg_id", 32'(bus.set_reg_id), 32'd0);
    cyc();
    flush        = 1'b0;
    bus.wb_valid = 1'b0;
    bus.alloc_rd = 5'd6;
    probe();
    chk("lit_after_flush_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    cyc();
    bus.alloc_valid = 1'b0;

    // Pause holds a ready head
    do_reset();
    alloc(5'd7);
`ifdef ROB_COMMIT_BYPASS_EN
    rdy = 1'b0;
    wb(0, 32'h77);
    probe();
    chk("lit_pause_set_reg_id", 32'(bus.set_reg_id), 32'd0);
    chk("lit_pause_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    cyc();
    rdy = 1'b1;
    probe();
    chk("lit_same_cycle_commit_rd", 32'(bus.set_reg_id), 32'd7);
    chk("lit_same_cycle_commit_val", bus.set_val, 32'h77);
    cyc();
    bus.wb_valid = 1'b0;
`else
    wb(0, 32'h77);
    cyc();
    bus.wb_valid = 1'b0;
    rdy = 1'b0;
    probe();
    chk("lit_pause_set_reg_id", 32'(bus.set_reg_id), 32'd0);
    chk("lit_pause_alloc_ready", {31'b0, bus.alloc_ready}, 32'd0);
    cyc();
    cyc();
    rdy = 1'b1;
    probe();
    chk("lit_resume_commit_rd", 32'(bus.set_reg_id), 32'd7);
    chk("lit_resume_commit_val", bus.set_val, 32'h77);
    cyc();
`endif

    // Randomized traffic, model-checked every cycle
    do_reset();
    for (int c = 0; c < 5000; c++) begin
      rdy             = ($urandom_range(0, 7) != 0);
      flush           = ($urandom_range(0, 79) == 0);
      bus.alloc_valid = ($urandom_range(0, 9) < 6);
      bus.alloc_rd    = 5'($urandom_range(0, 31));
      bus.wb_valid    = ($urandom_range(0, 9) < 7);
      bus.wb_rob_id   = W'($urandom_range(0, D - 1));
      bus.wb_val      = $urandom;
      bus.query_id1   = W'($urandom_range(0, D - 1));
      bus.query_id2   = W'($urandom_range(0, D - 1));
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc();
    end
    idle();
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

- Circular in-order reorder buffer between issue, the common data bus (CDB) and `RegisterFile`.
- Allocates one entry per issued instruction and drives the dependency-rename port `set_dep_*`.
- Captures CDB results and answers operand queries from issue.
- Retires the head entry through the commit port `set_reg_id` / `set_val` / `set_reg_on_rob_id`, which `RegisterFile` samples on the same clock edge.

## Interface
- `ROB_WIDTH_BIT`, default 4: entry index width; depth `2**ROB_WIDTH_BIT` (16).
- `clk_in` input 1: system clock; all state updates on posedge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rdy_in` input 1: pause when low; no state change, `alloc_ready`=0, commit outputs forced to 0.
- `flush_in` input 1: synchronous flush (mispredict); empties buffer.
- `alloc_valid` input 1: issue requests an entry this cycle.
- `alloc_rd` input 5: destination register; 0 = no register write.
- `alloc_ready` output 1: entry accepted this cycle if `alloc_valid`.
- `alloc_rob_id` output ROB_WIDTH_BIT: index given to the allocating instruction (= tail).
- `set_dep_reg_id` output 5: rename target to `RegisterFile`; 0 when no accepted allocation.
- `set_dep_rob_id` output ROB_WIDTH_BIT: equals `alloc_rob_id`.
- `wb_valid` input 1: CDB result valid.
- `wb_rob_id` input ROB_WIDTH_BIT: entry being completed.
- `wb_val` input 32: result value.
- `query_id1`, `query_id2` input ROB_WIDTH_BIT: entries whose values issue wants.
- `query_ready1`, `query_ready2` output 1: entry has its value.
- `query_val1`, `query_val2` output 32: entry value; undefined when not ready.
- `set_reg_id` output 5: commit destination; 0 = no write.
- `set_val` output 32: commit value.
- `set_reg_on_rob_id` output ROB_WIDTH_BIT: index of committing entry (= head).

## Operation
- State:
  - per-entry `busy`, `ready`, `rd[4:0]`, `val[31:0]`;
  - `head`, `tail` (ROB_WIDTH_BIT, wrap modulo depth);
  - `count` (ROB_WIDTH_BIT+1 bits, 0..depth).
- Allocate:
  - accepted = `alloc_valid && alloc_ready`, with `alloc_ready = rdy_in && !flush_in && count != depth`;
  - not ready when full, even if a commit happens the same cycle;
  - on accept: entry[tail] ← busy=1, ready=0, rd=`alloc_rd`; tail++.
  - `set_dep_reg_id` = accepted ? `alloc_rd` : 0 (combinational).
- Writeback: if `wb_valid` and entry[`wb_rob_id`].busy: ready←1, val←`wb_val`. Writes to non-busy entries are ignored.
- Commit:
  - commit = `rdy_in && !flush_in && busy[head] && ready[head]`;
  - outputs `set_reg_id`=rd[head], `set_val`=val[head], `set_reg_on_rob_id`=head, combinational from registered state;
  - all three are 0 when not committing;
  - on posedge: busy[head]←0, head++.
  - An rd=0 entry commits normally with `set_reg_id`=0.
- At most one allocate, one writeback and one commit per cycle. count += accept − commit.
- Query:
  - `query_ready` = busy & ready of the entry, OR (`wb_valid` && `wb_rob_id` == query id && entry busy);
  - on that bypass hit, `query_val`=`wb_val`.
- Flush:
  - all busy←0, head←0, tail←0, count←0;
  - no allocate, writeback or commit takes effect that cycle.

## Timing
- Reset: all outputs 0 except `alloc_ready`, which is 1 once `rst_n_in` is high with `rdy_in`=1; all entries not busy; head/tail/count=0.
- Reset asserted mid-operation clears state immediately and asynchronously; in-flight CDB results are lost.
- Allocate → visible to query: next cycle.
- Writeback → commit of that entry: earliest the next cycle (1-cycle min latency) when the entry is head.
- Full (count=depth): `alloc_ready`=0. Empty: no commit.
- Wrap: tail 15→0 and head 15→0 (depth 16) with no bubble.
- Simultaneous allocate+commit at count=1 or full−1: count unchanged; pointers both advance.
- Priority: `rst_n_in` > `rdy_in` low > `flush_in` > normal.

## Configuration
- `ROB_COMMIT_BYPASS_EN`:
  - Defined: head also commits in the same cycle its writeback arrives. The commit outputs take `wb_val`, giving 0-cycle writeback→commit latency. The entry must not be re-marked ready after it is freed.
  - Undefined: commit only from the registered `ready` flag (1-cycle latency, shorter path).

## Test plan
- Reset, allocate rd=5 → `set_dep_reg_id`=5, `set_dep_rob_id`=0. `wb_valid` id0 val=0x1234 → next cycle `set_reg_id`=5, `set_val`=0x1234, `set_reg_on_rob_id`=0.
- Allocate 16 entries with no writeback → `alloc_ready`=0 and the 17th request is refused. Writeback id0, commit → allocation resumes at tail=0 (wrap).
- Out-of-order writeback to ids 2,1,0 → commits occur in order 0,1,2 on consecutive cycles.
- Query id3 while `wb_valid` id3 val=0xABCD → `query_ready`=1, `query_val`=0xABCD the same cycle.
- 8 entries in flight, `flush_in`=1 → count=0, no commit output. Next allocation gets rob_id 0.
- `rdy_in`=0 with a ready head → `set_reg_id`=0 and head is held. With `ROB_COMMIT_BYPASS_EN` defined, writeback to head commits in the same cycle.
